// File: rtl/multicycle_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a bus-timeout fault.
// Optional retired-instruction counter enabled by MULTICYCLE_SEQ_RETIRE_CNT_EN.
module multicycle_seq #(
    parameter int TO_LIMIT = 15,
    parameter int TO_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        bus_err,
    output logic [2:0]  state,
    output logic [15:0] retire_cnt
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_JR   = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_SW   = 3'd6;
    localparam logic [2:0] OP_J    = 3'd7;

    // Counter value at which one more unanswered request cycle means a timeout.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
    localparam logic [TO_W-1:0] WAIT_ONE = TO_W'(1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            bus_err_q, bus_err_d;
    logic            wait_req_s;
    logic            wait_rdy_s;
    logic [2:0]      opcode_s;
    logic            unused_instr_s;

    assign opcode_s       = instr[7:5];
    assign unused_instr_s = ^instr[4:0];
    assign state          = state_q;
    assign bus_err        = bus_err_q;

    // Next-state and strobe decode.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        wait_req_s  = 1'b0;
        wait_rdy_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req   = run;
                wait_req_s = run;
                wait_rdy_s = imem_ready;
                if (run && imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = 2'b00;
                    state_d = ST_DECODE;
                end else if (run && (wait_q == TO_LAST)) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_ADD:  begin alu_op = 2'b00; state_d = ST_WB; end
                    OP_SUB:  begin alu_op = 2'b01; state_d = ST_WB; end
                    OP_AND:  begin alu_op = 2'b10; state_d = ST_WB; end
                    OP_ADDI: begin alu_src_imm = 1'b1; state_d = ST_WB; end
                    OP_LW, OP_SW: begin
                        alu_src_imm = 1'b1;
                        state_d     = ST_MEM;
                    end
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b01;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_JR: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b10;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dmem_req    = 1'b1;
                alu_src_imm = 1'b1;
                dmem_we     = (opcode_s == OP_SW);
                wait_req_s  = 1'b1;
                wait_rdy_s  = dmem_ready;
                if (dmem_ready) begin
                    if (opcode_s == OP_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == TO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                reg_we      = 1'b1;
                mem_to_reg  = (opcode_s == OP_LW);
                alu_src_imm = (opcode_s == OP_ADDI);
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Wait counter runs only while a request is outstanding in the same state.
    always_comb begin
        wait_d    = '0;
        bus_err_d = bus_err_q | (state_d == ST_FAULT);
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (wait_req_s && !wait_rdy_s) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = '0;
        end
    end

    // State, wait counter and sticky fault registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef MULTICYCLE_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_comb begin
        if (retire) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= 16'h0000;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed self-checking bench for multicycle_seq (default TO_LIMIT=15).
module tb_multicycle_seq;

    logic        clk, reset, run, imem_ready, dmem_ready;
    logic [7:0]  instr;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]  pc_src, alu_op;
    logic        alu_src_imm, reg_we, mem_to_reg, retire, bus_err;
    logic [2:0]  state;
    logic [15:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int c0 = 0;
    int exp_rc = 0;

    localparam logic [12:0] S_IMEM = 13'h1000, S_DREQ = 13'h0800, S_DWE = 13'h0400;
    localparam logic [12:0] S_IRWE = 13'h0200, S_PCWE = 13'h0100;
    localparam logic [12:0] S_PCREL = 13'h0040, S_PCREG = 13'h0080;
    localparam logic [12:0] S_SUB = 13'h0010, S_AND = 13'h0020, S_IMM = 13'h0008;
    localparam logic [12:0] S_REGWE = 13'h0004, S_M2R = 13'h0002, S_RET = 13'h0001;

    multicycle_seq dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .retire(retire), .bus_err(bus_err), .state(state), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [12:0] strobes();
        return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op,
                alu_src_imm, reg_we, mem_to_reg, retire};
    endfunction

    function automatic int rc_model(int n);
`ifdef MULTICYCLE_SEQ_RETIRE_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs(input string tag, input logic [2:0] st, input logic [12:0] sb);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strobes"}, 32'(strobes()), 32'(sb));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Leaves the sequencer in EXEC, sampled mid-cycle.
    task automatic do_fetch(input logic [7:0] ins);
        instr = ins; run = 1'b1; imem_ready = 1'b1; #1;
        cs("fetch", 3'd0, S_IMEM | S_IRWE | S_PCWE);
        c0 = cyc_cnt;
        adv(); imem_ready = 1'b0; #1;
        cs("decode", 3'd1, 13'h0000);
        adv(); #1;
    endtask

    logic [7:0]  tbl_ins [4];
    logic [12:0] tbl_ex  [4];
    logic [12:0] tbl_wb  [4];

    initial begin
        tbl_ins = '{8'h00, 8'h20, 8'h40, 8'h85};
        tbl_ex  = '{13'h0000, S_SUB, S_AND, S_IMM};
        tbl_wb  = '{S_REGWE | S_RET, S_REGWE | S_RET, S_REGWE | S_RET, S_IMM | S_REGWE | S_RET};

        reset = 1'b1; run = 1'b0; instr = 8'h00; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #2;
        cs("reset", 3'd0, 13'h0000);
        chk("reset.bus_err", 32'(bus_err), 32'd0);
        chk("reset.retire_cnt", 32'(retire_cnt), 32'd0);
        @(negedge clk); reset = 1'b0;
        adv();

        // ALU-class instructions: 4 cycles each
        for (int i = 0; i < 4; i++) begin
            do_fetch(tbl_ins[i]);
            cs("alu.exec", 3'd2, tbl_ex[i]);
            adv(); #1;
            cs("alu.wb", 3'd4, tbl_wb[i]);
            adv(); #1;
            cs("alu.ret", 3'd0, S_IMEM);
            chk("alu.latency", 32'(cyc_cnt - c0), 32'd4);
            exp_rc++;
            chk("alu.retire_cnt", 32'(retire_cnt), 32'(rc_model(exp_rc)));
        end

        // LW with dmem_ready on the fourth request cycle: 8 cycles
        do_fetch(8'b101_00011);
        cs("lw.exec", 3'd2, S_IMM);
        for (int i = 0; i < 3; i++) begin
            adv(); dmem_ready = 1'b0; #1;
            cs("lw.mem_wait", 3'd3, S_DREQ | S_IMM);
        end
        adv(); dmem_ready = 1'b1; #1;
        cs("lw.mem_rdy", 3'd3, S_DREQ | S_IMM);
        adv(); dmem_ready = 1'b0; #1;
        cs("lw.wb", 3'd4, S_REGWE | S_M2R | S_RET);
        adv(); #1;
        chk("lw.latency", 32'(cyc_cnt - c0), 32'd8);
        exp_rc++;

        // SW with immediate dmem_ready: retires in MEM, 4 cycles
        do_fetch(8'b110_11111);
        cs("sw.exec", 3'd2, S_IMM);
        adv(); dmem_ready = 1'b1; #1;
        cs("sw.mem", 3'd3, S_DREQ | S_DWE | S_IMM | S_RET);
        adv(); dmem_ready = 1'b0; #1;
        cs("sw.ret", 3'd0, S_IMEM);
        chk("sw.latency", 32'(cyc_cnt - c0), 32'd4);
        exp_rc++;

        // J then JR: 3 cycles each
        do_fetch(8'b111_11110);
        cs("j.exec", 3'd2, S_PCWE | S_PCREL | S_RET);
        adv(); #1;
        chk("j.latency", 32'(cyc_cnt - c0), 32'd3);
        exp_rc++;
        do_fetch(8'b011_00000);
        cs("jr.exec", 3'd2, S_PCWE | S_PCREG | S_RET);
        adv(); #1;
        chk("jr.latency", 32'(cyc_cnt - c0), 32'd3);
        exp_rc++;
        chk("jr.retire_cnt", 32'(retire_cnt), 32'(rc_model(exp_rc)));

        // imem_ready arrives on the 15th request cycle: ready wins, no fault
        instr = 8'h00; imem_ready = 1'b0; #1;
        for (int i = 1; i < 14; i++) begin
            adv(); #1;
        end
        cs("late.wait14", 3'd0, S_IMEM);
        adv(); imem_ready = 1'b1; #1;
        cs("late.fetch15", 3'd0, S_IMEM | S_IRWE | S_PCWE);
        adv(); imem_ready = 1'b0; #1;
        cs("late.decode", 3'd1, 13'h0000);
        chk("late.bus_err", 32'(bus_err), 32'd0);
        adv(); adv(); adv(); #1;
        exp_rc++;
        chk("late.retire_cnt", 32'(retire_cnt), 32'(rc_model(exp_rc)));

        // imem_ready never arrives: fault after 15 request cycles
        cs("to.cycle1", 3'd0, S_IMEM);
        for (int i = 1; i < 15; i++) begin
            adv(); #1;
        end
        cs("to.cycle15", 3'd0, S_IMEM);
        adv(); #1;
        cs("to.fault", 3'd7, 13'h0000);
        chk("to.bus_err", 32'(bus_err), 32'd1);
        imem_ready = 1'b1;
        adv(); adv(); adv(); #1;
        cs("to.held", 3'd7, 13'h0000);
        chk("to.held_bus_err", 32'(bus_err), 32'd1);
        run = 1'b0; reset = 1'b1; #1;
        cs("to.reset", 3'd0, 13'h0000);
        chk("to.reset_bus_err", 32'(bus_err), 32'd0);
        chk("to.reset_retire_cnt", 32'(retire_cnt), 32'd0);
        @(negedge clk); reset = 1'b0;

        // run=0: no requests and no fault even with imem_ready high
        for (int i = 0; i < 20; i++) begin
            adv(); #1;
        end
        cs("idle.after20", 3'd0, 13'h0000);
        chk("idle.bus_err", 32'(bus_err), 32'd0);
        adv();

        // Reset in the middle of a data access drops dmem_req at once
        do_fetch(8'b101_00011);
        adv(); dmem_ready = 1'b0; #1;
        cs("rmem.mem", 3'd3, S_DREQ | S_IMM);
        #2; run = 1'b0; reset = 1'b1; #1;
        cs("rmem.reset", 3'd0, 13'h0000);
        @(negedge clk); reset = 1'b0;
        adv(); #1;
        cs("rmem.after", 3'd0, 13'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
Multi-cycle control sequencer for the 8-bit computer. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes: PC/IR/register-file write enables, ALU op and source select, PC source, and memory request. It sits beside the combinational decode and owns all timing, memory handshakes and the bus-timeout fault.

Parameters:
TO_LIMIT, 15, maximum wait cycles for imem_ready/dmem_ready before bus fault (1..255)
TO_W, 8, width of the internal wait counter; must hold TO_LIMIT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  1 = sequencer may start a new fetch
instr  input  8  instruction from IR; opcode = instr[7:5]
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (valid only with dmem_req)
ir_we  output  1  latch instruction into IR
pc_we  output  1  update PC
pc_src  output  2  00 = PC+1, 01 = PC+signext(imm5), 10 = register (JR)
alu_op  output  2  00 = add, 01 = sub, 10 = and
alu_src_imm  output  1  ALU operand B = sign-extended instr[4:0]
reg_we  output  1  register file write
mem_to_reg  output  1  writeback data source is memory
retire  output  1  one-cycle pulse when an instruction completes
bus_err  output  1  sticky bus-timeout fault
state  output  3  current state, for debug
retire_cnt  output  16  retired-instruction count (see Optional Feature)

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 JR, 100 ADDI, 101 LW, 110 SW, 111 J.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Reset (async, any time, mid-access included): state=FETCH, wait counter=0, bus_err=0, retire_cnt=0. All other outputs are 0.
- Outputs are 0 unless listed below.
- FETCH:
  - imem_req = run.
  - When imem_ready=1 and run=1: ir_we=1, pc_we=1, pc_src=00 in the same cycle; next state DECODE.
  - When run=0: hold in FETCH, no request, wait counter held at 0.
- DECODE: one cycle, no strobes; next state EXEC.
- EXEC:
  - ADD/SUB/AND: alu_op = 00/01/10; next WB.
  - ADDI: alu_op=00, alu_src_imm=1; next WB.
  - LW/SW: alu_op=00, alu_src_imm=1 (address = base + imm); next MEM.
  - J: pc_we=1, pc_src=01, retire=1; next FETCH.
  - JR: pc_we=1, pc_src=10, retire=1; next FETCH.
- MEM:
  - dmem_req=1, alu_src_imm=1; dmem_we=1 for SW only. dmem_req stays high until dmem_ready.
  - On dmem_ready: SW gives retire=1, next FETCH; LW gives next WB.
- WB:
  - reg_we=1; mem_to_reg=1 for LW, else 0; alu_src_imm=1 for ADDI.
  - retire=1; next FETCH.
- Latency in cycles, with ready on the first request cycle: ALU/ADDI 4, LW 5, SW 4, J/JR 3.
- A ready input sampled in a cycle with no request is ignored.
- Timeout:
  - The wait counter increments each cycle a request is high and ready is low.
  - It clears on ready or on a state change.
  - If it reaches TO_LIMIT with ready still low, next state is FAULT and bus_err becomes 1.
  - Ready arriving in the same cycle the counter reaches TO_LIMIT wins: normal transition, no fault.
- FAULT: all strobes 0, bus_err=1; held until reset. run is ignored.
- instr is sampled only in EXEC, MEM and WB. The IR must stay stable from DECODE through WB.

Optional Feature:
MULTICYCLE_SEQ_RETIRE_CNT_EN
- Defined: retire_cnt is a 16-bit counter that increments on each retire pulse and wraps from 0xFFFF to 0x0000. Reset clears it.
- Undefined: retire_cnt is tied to 16'h0000. The port remains, so the port list is identical in both builds.

Test Plan:
- Reset, run=1, imem_ready=1, instr=8'b000_00000 (ADD): states 0→1→2→4→0; alu_op=00 in EXEC; reg_we=1 and retire=1 in WB; 4 cycles per instruction; retire_cnt=1 if enabled.
- LW (8'b101_00011), dmem_ready delayed 3 cycles: dmem_req high 4 cycles with dmem_we=0; then WB with mem_to_reg=1; total 8 cycles.
- SW (8'b110_11111): MEM asserts dmem_req=1 and dmem_we=1; retire occurs on the dmem_ready cycle; reg_we never asserted.
- J (8'b111_11110) then JR (8'b011_00000): EXEC asserts pc_we with pc_src=01 then 10; 3 cycles each; no reg_we.
- imem_ready held 0 with TO_LIMIT=15: after 15 request cycles, state=7 and bus_err=1, imem_req=0. Repeat with ready on the 15th cycle: no fault. Assert reset in FAULT: outputs return to 0 and state returns to 0.
- run=0 during FETCH: no imem_req for 20 cycles, no fault. Reset asserted mid-MEM: dmem_req drops immediately (async), state=0.
